// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// digits_needed() lets an instantiating block size DIGITS from its binary width.
package bin_to_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int BCD_DIGIT_W = 4;

   // ceil(bin_w * log10(2)) in integer arithmetic, log10(2) ~= 0.30103
   function automatic int digits_needed(input int bin_w);
      return (bin_w * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit shift-and-add-3 corrector: digits of 5..9 get +3 before the next doubling.
module bcd_add3
   import bin_to_bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   always_comb begin
      digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock,
// with valid/ready handshakes on both sides and a held result register.
module bin_to_bcd_seq
   import bin_to_bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BIN_W-1:0]              bin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          overflow
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   digits_q, digits_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic               overflow_q, overflow_d;
   logic [BCD_W-1:0]   corr;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_in  (digits_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_out (corr[i*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      digits_d   = digits_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shreg_d  = bin;
               digits_d = '0;
               ovf_d    = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            // A carry out of the top digit means the value no longer fits in DIGITS.
            digits_d = {corr[BCD_W-2:0], shreg_q[BIN_W-1]};
            shreg_d  = shreg_q << 1;
            ovf_d    = ovf_q | corr[BCD_W-1];
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d    = DONE;
               bcd_d      = digits_d;
               overflow_d = ovf_d;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         digits_q   <= '0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         digits_q   <= digits_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign bcd       = bcd_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: three converter configurations run side by side against a
// decimal-arithmetic reference model, plus directed literal cases, stall and mid-conversion reset.
module tb_bin_to_bcd_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   localparam int NRAND = 1500;

   localparam logic [19:0] DIR_OP  [3][3] = '{'{20'd255, 20'd0, 20'd128},
                                             '{20'd255, 20'd99, 20'd0},
                                             '{20'd65535, 20'd10000, 20'd0}};
   localparam logic [19:0] DIR_EXP [3][3] = '{'{20'h00255, 20'h00000, 20'h00128},
                                             '{20'h00055, 20'h00099, 20'h00000},
                                             '{20'h65535, 20'h10000, 20'h00000}};
   localparam logic [19:0] DIR_OVF [3][3] = '{'{20'd0, 20'd0, 20'd0},
                                             '{20'd1, 20'd0, 20'd0},
                                             '{20'd0, 20'd0, 20'd0}};

   function automatic int unsigned pow10(input int dg);
      int unsigned p = 1;
      for (int i = 0; i < dg; i++) p = p * 10;
      return p;
   endfunction

   // Decimal digits of v, least significant first, keeping only dg of them.
   function automatic logic [19:0] ref_bcd(input int unsigned v, input int dg);
      logic [19:0] r = '0;
      int unsigned x = v;
      for (int i = 0; i < dg; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int BW = (g == 2) ? 16 : 8;
      localparam int DG = (g == 0) ? 4 : ((g == 1) ? 2 : 5);

      logic            rst_n, in_valid, in_ready, out_valid, out_ready, overflow;
      logic [BW-1:0]   bin;
      logic [4*DG-1:0] bcd;
      bit              done = 1'b0;
      bit              started = 1'b0;

      bin_to_bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .bin       (bin),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .bcd       (bcd),
         .overflow  (overflow)
      );

      // Reference: 0 = accepting, 1 = busy for BW edges, 2 = holding a result.
      int          m_mode = 0;
      int          m_left = 0;
      logic [19:0] m_pend = '0;
      logic [19:0] m_bcd  = '0;
      logic        m_povf = 1'b0;
      logic        m_ovf  = 1'b0;

      always @(posedge clk) begin
         if (!rst_n) begin
            m_mode  = 0;
            m_bcd   = '0;
            m_ovf   = 1'b0;
            started = 1'b1;
         end else begin
            case (m_mode)
               0: if (in_valid) begin
                  m_mode = 1;
                  m_left = BW;
                  m_pend = ref_bcd(int'(bin), DG);
                  m_povf = (int'(bin) >= pow10(DG));
               end
               1: begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_mode = 2;
                     m_bcd  = m_pend;
                     m_ovf  = m_povf;
                  end
               end
               default: if (out_ready) m_mode = 0;
            endcase
         end
      end

      always @(negedge clk) begin
         if (started) begin
            checkOutput($sformatf("cfg%0d in_ready", g), 32'(in_ready), 32'(m_mode == 0));
            checkOutput($sformatf("cfg%0d out_valid", g), 32'(out_valid), 32'(m_mode == 2));
            checkOutput($sformatf("cfg%0d bcd", g), 32'(bcd), 32'(m_bcd[4*DG-1:0]));
            checkOutput($sformatf("cfg%0d overflow", g), 32'(overflow), 32'(m_ovf));
         end
      end

      task automatic applyStimulus(input logic [BW-1:0] v);
         bit acc = 1'b0;
         int n = 0;
         in_valid = 1'b1;
         bin      = v;
         while (!acc && n < 200) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
         end
         in_valid = 1'b0;
         if (!acc) checkOutput($sformatf("cfg%0d accept_timeout", g), 32'(acc), 32'd1);
      endtask

      task automatic waitResult();
         int n = 0;
         while (!out_valid && n < BW + 10) begin
            @(posedge clk);
            #1;
            n++;
         end
         checkOutput($sformatf("cfg%0d latency", g), 32'(n), 32'(BW));
      endtask

      task automatic takeResult();
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      endtask

      initial begin
         logic [4*DG-1:0] saved;
         int acc_cnt = 0;
         int cyc = 0;
         rst_n     = 1'b0;
         in_valid  = 1'b0;
         out_ready = 1'b0;
         bin       = '0;
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         checkOutput($sformatf("cfg%0d rst_in_ready", g), 32'(in_ready), 32'd1);
         checkOutput($sformatf("cfg%0d rst_out_valid", g), 32'(out_valid), 32'd0);
         checkOutput($sformatf("cfg%0d rst_bcd", g), 32'(bcd), 32'd0);

         for (int k = 0; k < 3; k++) begin
            applyStimulus(BW'(DIR_OP[g][k]));
            waitResult();
            checkOutput($sformatf("cfg%0d dir%0d_bcd", g, k), 32'(bcd), 32'(DIR_EXP[g][k][4*DG-1:0]));
            checkOutput($sformatf("cfg%0d dir%0d_ovf", g, k), 32'(overflow), 32'(DIR_OVF[g][k][0]));
            takeResult();
            checkOutput($sformatf("cfg%0d dir%0d_held", g, k), 32'(bcd), 32'(DIR_EXP[g][k][4*DG-1:0]));
         end

         // Consumer stalls for 20 cycles while the producer keeps poking in_valid.
         applyStimulus(BW'($urandom));
         waitResult();
         saved = bcd;
         for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            bin      = BW'($urandom);
            @(posedge clk);
            #1;
            checkOutput($sformatf("cfg%0d stall_valid", g), 32'(out_valid), 32'd1);
            checkOutput($sformatf("cfg%0d stall_ready", g), 32'(in_ready), 32'd0);
            checkOutput($sformatf("cfg%0d stall_bcd", g), 32'(bcd), 32'(saved));
         end
         in_valid = 1'b0;
         takeResult();
         checkOutput($sformatf("cfg%0d release_ready", g), 32'(in_ready), 32'd1);
         checkOutput($sformatf("cfg%0d release_valid", g), 32'(out_valid), 32'd0);

         // Reset lands on the edge after cnt reaches 3.
         applyStimulus(BW'(200));
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         checkOutput($sformatf("cfg%0d midrst_ready", g), 32'(in_ready), 32'd1);
         checkOutput($sformatf("cfg%0d midrst_valid", g), 32'(out_valid), 32'd0);
         checkOutput($sformatf("cfg%0d midrst_bcd", g), 32'(bcd), 32'd0);
         applyStimulus(BW'(42));
         waitResult();
         checkOutput($sformatf("cfg%0d after_rst_bcd", g), 32'(bcd), 32'h42);
         takeResult();

         while (acc_cnt < NRAND && cyc < 60000) begin
            in_valid = ($urandom % 4) != 0;
            case ($urandom % 6)
               0:       bin = '0;
               1:       bin = '1;
               2:       bin = BW'(pow10(DG) - 1);
               3:       bin = BW'(pow10(DG));
               default: bin = BW'($urandom);
            endcase
            out_ready = ($urandom % 3) != 0;
            if (in_valid && in_ready) acc_cnt++;
            @(posedge clk);
            #1;
            cyc++;
         end
         if (acc_cnt < NRAND) checkOutput($sformatf("cfg%0d random_timeout", g), 32'(acc_cnt), 32'(NRAND));
         in_valid  = 1'b0;
         out_ready = 1'b1;
         repeat (BW + 4) @(posedge clk);
         #1;
         done = 1'b1;
      end
   end

   initial begin
      int n = 0;
      while (!(cfg[0].done && cfg[1].done && cfg[2].done) && n < 90000) begin
         @(posedge clk);
         n++;
      end
      if (!(cfg[0].done && cfg[1].done && cfg[2].done)) begin
         errors++;
         $display("[TB] FAIL global_timeout: got %0d cycles expected completion", n);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
